writeback_controller: RTL and testbench

Writeback-stage initiator for the register file's write port. Accepts completed instruction results from the execute/memory stage into a small FIFO, selects and formats the destination value, and drives the register file's `writeBackEnable`/`writeEnable`/`instruction`/`writeData` inputs. It waits for `writeBackComplete` before retiring each writing instruction. It also counts retired instructions and flags a lost handshake.

---
 rtl/writeback_controller.sv | 206 ++++++++++++++++++++
 tb/tb_writeback_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_controller.sv
// Writeback-stage initiator: buffers execute/memory results in a small FIFO,
// formats the destination value, drives the register-file write port and
// waits for its acknowledge before retiring. Counts retirements and flags a
// lost handshake (sticky).
//
// Handshakes:
//   upstream  : a result is accepted on a posedge where resultValid && resultReady;
//               resultReady depends only on the current fill level (no bypass).
//   reg-file  : writeBackEnable/writeEnable are a one-cycle strobe; writeBackComplete
//               is only sampled while waiting for the acknowledge.
module writeback_controller #(
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        resultValid,
    output logic        resultReady,
    input  logic [31:0] resultInstruction,
    input  logic [31:0] aluResult,
    input  logic [31:0] memData,
    input  logic [31:0] pcPlus4,
    output logic        writeBackEnable,
    output logic        writeEnable,
    output logic [31:0] instruction,
    output logic [31:0] writeData,
    input  logic        writeBackComplete,
    output logic        retireValid,
    output logic [31:0] retireCount,
    output logic        timeoutError
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [TMR_W-1:0]   timer, timer_next;

    logic [31:0]        fifo_instr [FIFO_DEPTH];
    logic [31:0]        fifo_data  [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_writes;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;

    logic        push, pop, do_issue, do_retire, do_timeout;
    logic        in_writes;
    logic [31:0] in_data, load_val, mem_shifted;
    logic [15:0] half_sel;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;

    assign opcode      = resultInstruction[6:0];
    assign rd          = resultInstruction[11:7];
    assign funct3      = resultInstruction[14:12];
    assign resultReady = (count < CNT_W'(FIFO_DEPTH));
    assign push        = resultValid && resultReady;

    // Pick the byte/halfword addressed by the load offset.
    assign mem_shifted = memData >> {aluResult[1:0], 3'b000};
    assign half_sel    = aluResult[1] ? memData[31:16] : memData[15:0];

    // Classify the incoming result and format its destination value.
    always_comb begin
        in_writes = 1'b0;
        load_val  = memData;
        in_data   = aluResult;
        case (funct3)
            3'b000:  load_val = {{24{mem_shifted[7]}}, mem_shifted[7:0]};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'h0, mem_shifted[7:0]};
            3'b101:  load_val = {16'h0, half_sel};
            default: load_val = memData;
        endcase
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: in_writes = (rd != 5'd0);
            OPC_JAL, OPC_JALR: begin
                in_writes = (rd != 5'd0);
                in_data   = pcPlus4;
            end
            OPC_LOAD: begin
                in_writes = (rd != 5'd0);
                in_data   = load_val;
            end
            default: in_writes = 1'b0;
        endcase
    end

    // FIFO storage; contents are only read while the entry is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_instr[wr_ptr]  <= resultInstruction;
            fifo_data[wr_ptr]   <= in_data;
            fifo_writes[wr_ptr] <= in_writes;
        end
    end

    // FIFO pointers and fill level; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // State and handshake timer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // Next-state logic: issue writers, retire non-writers directly, time out lost acks.
    always_comb begin
        state_next = state;
        timer_next = timer;
        pop        = 1'b0;
        do_issue   = 1'b0;
        do_retire  = 1'b0;
        do_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    if (fifo_writes[rd_ptr]) begin
                        do_issue   = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        pop       = 1'b1;
                        do_retire = 1'b1;
                    end
                end
            end
            ISSUE: begin
                timer_next = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (writeBackComplete) begin
                    pop        = 1'b1;
                    do_retire  = 1'b1;
                    state_next = IDLE;
                end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    pop        = 1'b1;
                    do_timeout = 1'b1;
                    timer_next = '0;
                    state_next = IDLE;
                end else begin
                    timer_next = timer + TMR_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered register-file port, retire pulse/counter and sticky error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            writeBackEnable <= 1'b0;
            writeEnable     <= 1'b0;
            instruction     <= '0;
            writeData       <= '0;
            retireValid     <= 1'b0;
            retireCount     <= '0;
            timeoutError    <= 1'b0;
        end else begin
            writeBackEnable <= do_issue;
            writeEnable     <= do_issue;
            retireValid     <= do_retire;
            if (do_issue) begin
                instruction <= fifo_instr[rd_ptr];
                writeData   <= fifo_data[rd_ptr];
            end
            if (do_retire)  retireCount  <= retireCount + 32'd1;
            if (do_timeout) timeoutError <= 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_controller.sv
// Directed bench for writeback_controller with a register-file responder model
// and a scoreboard of expected {instruction, writeData} per issued write.
module tb_writeback_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        resultValid = 1'b0;
    logic        resultReady;
    logic [31:0] resultInstruction = '0;
    logic [31:0] aluResult = '0;
    logic [31:0] memData = '0;
    logic [31:0] pcPlus4 = '0;
    logic        writeBackEnable;
    logic        writeEnable;
    logic [31:0] instruction;
    logic [31:0] writeData;
    logic        writeBackComplete = 1'b0;
    logic        retireValid;
    logic [31:0] retireCount;
    logic        timeoutError;

    writeback_controller #(.FIFO_DEPTH(2), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset),
        .resultValid(resultValid), .resultReady(resultReady),
        .resultInstruction(resultInstruction), .aluResult(aluResult),
        .memData(memData), .pcPlus4(pcPlus4),
        .writeBackEnable(writeBackEnable), .writeEnable(writeEnable),
        .instruction(instruction), .writeData(writeData),
        .writeBackComplete(writeBackComplete),
        .retireValid(retireValid), .retireCount(retireCount),
        .timeoutError(timeoutError)
    );

    // Clock
    always #5 clock = ~clock;

    // Register-file responder: acknowledge one cycle after seeing the strobe.
    logic model_en = 1'b1;
    logic wbe_seen = 1'b0;
    always @(negedge clock) wbe_seen = writeBackEnable;
    always @(posedge clock) begin
        #1;
        writeBackComplete = model_en && wbe_seen;
    end

    // Scoreboard state
    logic [63:0] exp_q[$];
    int          ret_cycles[$];
    int          tests = 0;
    int          fails = 0;
    int          cycle = 0;
    int          wbe_cnt = 0;
    bit          ready_low = 1'b0;
    logic [31:0] rc_exp = '0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Advance one cycle and sample outputs at the falling edge.
    task automatic tick();
        logic [63:0] e;
        @(negedge clock);
        cycle++;
        if (!resultReady) ready_low = 1'b1;
        if (writeBackEnable) begin
            wbe_cnt++;
            chk("wbe_pending", 32'(exp_q.size() != 0), 32'd1);
            chk("write_enable", {31'd0, writeEnable}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wb_instruction", instruction, e[63:32]);
                chk("wb_data", writeData, e[31:0]);
            end
        end
        if (retireValid) ret_cycles.push_back(cycle);
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] mem,
                        input logic [31:0] pc, input bit wr, input logic [31:0] exp_d);
        bit acc;
        acc = 1'b0;
        resultValid = 1'b1;
        resultInstruction = ins;
        aluResult = alu;
        memData = mem;
        pcPlus4 = pc;
        for (int k = 0; k < 40 && !acc; k++) begin
            acc = resultReady;
            tick();
        end
        resultValid = 1'b0;
        chk("push_accept", {31'd0, acc}, 32'd1);
        if (wr) exp_q.push_back({ins, exp_d});
        rc_exp += (wr && !(!model_en)) || !wr ? 32'd1 : 32'd0;
    endtask

    task automatic wait_retire(input int n);
        for (int k = 0; k < 60 && ret_cycles.size() < n; k++) tick();
        chk("retire_arrival", 32'(ret_cycles.size()), 32'(n));
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {17'h0, f3, rd, opc};
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, {31'd0, resultReady}, 32'd1);
        chk({tag, "_wbe"}, {30'd0, writeBackEnable, writeEnable}, 32'd0);
        chk({tag, "_retire_valid"}, {31'd0, retireValid}, 32'd0);
        chk({tag, "_timeout"}, {31'd0, timeoutError}, 32'd0);
        chk({tag, "_instruction"}, instruction, 32'd0);
        chk({tag, "_write_data"}, writeData, 32'd0);
        chk({tag, "_retire_count"}, retireCount, 32'd0);
    endtask

    initial begin
        int c0;
        // Reset
        repeat (2) @(negedge clock);
        check_reset_values("reset");
        reset = 1'b0;

        // ADDI x5: issue, ack, retire 3 cycles after push
        push(32'h00A00293, 32'h0000000A, 32'h0, 32'h0, 1'b1, 32'h0000000A);
        c0 = cycle;
        wait_retire(1);
        if (ret_cycles.size() > 0) chk("addi_latency", 32'(ret_cycles[0] - c0), 32'd3);
        chk("addi_wbe_cycles", 32'(wbe_cnt), 32'd1);
        chk("addi_count", retireCount, rc_exp);
        ret_cycles.delete();

        // Load formatting
        push(mk(3'b000, 5'd6, 7'b0000011), 32'h00000102, 32'h80FF7F01, 32'h0, 1'b1, 32'hFFFFFFFF);
        push(mk(3'b100, 5'd6, 7'b0000011), 32'h00000102, 32'h80FF7F01, 32'h0, 1'b1, 32'h000000FF);
        push(mk(3'b001, 5'd6, 7'b0000011), 32'h00000102, 32'h80FF7F01, 32'h0, 1'b1, 32'hFFFF80FF);
        push(mk(3'b010, 5'd6, 7'b0000011), 32'h00000100, 32'h80FF7F01, 32'h0, 1'b1, 32'h80FF7F01);
        wait_retire(4);
        chk("load_count", retireCount, rc_exp);
        ret_cycles.delete();

        // SW then ADDI x0: no write strobe, consecutive retires
        c0 = wbe_cnt;
        push(32'h00112023, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        push(32'h00000013, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        wait_retire(2);
        if (ret_cycles.size() > 1) chk("nonwrite_spacing", 32'(ret_cycles[1] - ret_cycles[0]), 32'd1);
        chk("nonwrite_no_wbe", 32'(wbe_cnt - c0), 32'd0);
        chk("nonwrite_count", retireCount, rc_exp);
        ret_cycles.delete();

        // JAL x1 uses the link value
        push(mk(3'b000, 5'd1, 7'b1101111), 32'h00000ABC, 32'h0, 32'h00000104, 1'b1, 32'h00000104);
        wait_retire(1);
        ret_cycles.delete();

        // Back-to-back ADDIs with a 2-deep buffer
        ready_low = 1'b0;
        push(32'h00100393, 32'h00000011, 32'h0, 32'h0, 1'b1, 32'h00000011);
        push(32'h00200413, 32'h00000022, 32'h0, 32'h0, 1'b1, 32'h00000022);
        push(32'h00300493, 32'h00000033, 32'h0, 32'h0, 1'b1, 32'h00000033);
        wait_retire(3);
        chk("b2b_ready_low", {31'd0, ready_low}, 32'd1);
        if (ret_cycles.size() > 2) begin
            chk("b2b_spacing_1", 32'(ret_cycles[1] - ret_cycles[0]), 32'd3);
            chk("b2b_spacing_2", 32'(ret_cycles[2] - ret_cycles[1]), 32'd3);
        end
        chk("b2b_count", retireCount, rc_exp);
        chk("b2b_drained", 32'(exp_q.size()), 32'd0);
        ret_cycles.delete();

        // Handshake timeout: responder silent
        model_en = 1'b0;
        push(32'h00500513, 32'h00000055, 32'h0, 32'h0, 1'b1, 32'h00000055);
        repeat (9) tick();
        chk("timeout_not_yet", {31'd0, timeoutError}, 32'd0);
        tick();
        chk("timeout_set", {31'd0, timeoutError}, 32'd1);
        repeat (3) tick();
        chk("timeout_no_retire", 32'(ret_cycles.size()), 32'd0);
        chk("timeout_count", retireCount, rc_exp);
        chk("timeout_sticky", {31'd0, timeoutError}, 32'd1);

        // Reset asynchronously in the middle of a WAIT
        push(32'h00600593, 32'h00000066, 32'h0, 32'h0, 1'b1, 32'h00000066);
        repeat (4) tick();
        #2 reset = 1'b1;
        #1 check_reset_values("async_reset");
        @(negedge clock);
        reset = 1'b0;
        repeat (5) tick();
        chk("post_reset_no_retire", 32'(ret_cycles.size()), 32'd0);
        chk("post_reset_count", retireCount, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
